// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad scan geometry, key-code map, debounce and frame encodings.
// Pure declarations, no logic; codes 17..19 are scan positions without an assigned function yet.
package calc_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 5;
    localparam int CODE_W   = 5;

    localparam logic [CODE_W-1:0] KEY_0   = 5'd0;
    localparam logic [CODE_W-1:0] KEY_1   = 5'd1;
    localparam logic [CODE_W-1:0] KEY_2   = 5'd2;
    localparam logic [CODE_W-1:0] KEY_3   = 5'd3;
    localparam logic [CODE_W-1:0] KEY_4   = 5'd4;
    localparam logic [CODE_W-1:0] KEY_5   = 5'd5;
    localparam logic [CODE_W-1:0] KEY_6   = 5'd6;
    localparam logic [CODE_W-1:0] KEY_7   = 5'd7;
    localparam logic [CODE_W-1:0] KEY_8   = 5'd8;
    localparam logic [CODE_W-1:0] KEY_9   = 5'd9;
    localparam logic [CODE_W-1:0] KEY_ADD = 5'd10;
    localparam logic [CODE_W-1:0] KEY_SUB = 5'd11;
    localparam logic [CODE_W-1:0] KEY_MUL = 5'd12;
    localparam logic [CODE_W-1:0] KEY_DIV = 5'd13;
    localparam logic [CODE_W-1:0] KEY_EQ  = 5'd14;
    localparam logic [CODE_W-1:0] KEY_CLR = 5'd15;
    localparam logic [CODE_W-1:0] KEY_BS  = 5'd16;

    typedef enum logic [1:0] {IDLE, CAND, PRESSED} deb_state_t;

    typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_kind_t;

    function automatic logic [CODE_W-1:0] key_code(input logic [1:0] col, input logic [2:0] row);
        return 5'(col) * 5'd5 + 5'(row);
    endfunction

endpackage

// File: rtl/keypad_frame_acc.sv
// Folds four column samples into one frame verdict (none / single key / multi), combinational at the column-3 sample.
// No backpressure: accepts every sample strobe; frame_vld is a same-cycle pulse with sample_vld on column 3.
module keypad_frame_acc
    import calc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_vld,
    input  logic [1:0]          col,
    input  logic [NUM_ROWS-1:0] rows_n,
    output logic                frame_vld,
    output logic [1:0]          frame_kind,
    output logic [CODE_W-1:0]   frame_code
);

    // acc_cnt saturates at 2: anything beyond one pressed contact is just "multi"
    logic [1:0]        acc_cnt;
    logic [CODE_W-1:0] acc_code;
    logic [1:0]        col_cnt;
    logic [2:0]        col_row;
    logic [2:0]        raw_sum;
    logic [1:0]        sum_cnt;
    logic [CODE_W-1:0] sum_code;

    always_comb begin
        col_cnt = 2'd0;
        col_row = 3'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!rows_n[r]) begin
                if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
                col_row = 3'(r);
            end
        end
    end

    always_comb begin
        raw_sum  = {1'b0, acc_cnt} + {1'b0, col_cnt};
        sum_cnt  = (raw_sum > 3'd2) ? 2'd2 : raw_sum[1:0];
        sum_code = (acc_cnt != 2'd0) ? acc_code : key_code(col, col_row);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt  <= 2'd0;
            acc_code <= '0;
        end else if (sample_vld) begin
            if (col == 2'd3) begin
                acc_cnt  <= 2'd0;
                acc_code <= '0;
            end else begin
                acc_cnt  <= sum_cnt;
                acc_code <= sum_code;
            end
        end
    end

    always_comb begin
        frame_vld  = sample_vld && (col == 2'd3);
        frame_code = sum_code;
        case (sum_cnt)
            2'd0:    frame_kind = FR_NONE;
            2'd1:    frame_kind = FR_SINGLE;
            default: frame_kind = FR_MULTI;
        endcase
    end

endmodule

// File: rtl/keypad_scan.sv
// Keypad column scanner + press/release debouncer; strobe one cycle after the column-3 sample of the accepting frame.
// No backpressure: the downstream stage must take o_bcd_data whenever o_key_valid pulses.
module keypad_scan
    import calc_pkg::*;
#(
    parameter int SCAN_TICKS = 2,
    parameter int DEB_FRAMES = 3,
    parameter int REL_FRAMES = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pls_1k,
    input  logic [NUM_ROWS-1:0] i_key_in,
    output logic [NUM_COLS-1:0] o_key_out,
    output logic [CODE_W-1:0]   o_bcd_data,
    output logic                o_key_valid
);

    localparam int         TW      = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [2:0] DEB_LIM = 3'(DEB_FRAMES);
    localparam logic [2:0] REL_LIM = 3'(REL_FRAMES);

    logic [TW-1:0] tick_cnt;
    logic [1:0]    col;
    logic          sample_vld;

    logic              frame_vld;
    logic [1:0]        frame_kind;
    logic [CODE_W-1:0] frame_code;
    logic              is_none;
    logic              is_single;

    deb_state_t        state, state_nxt;
    logic [CODE_W-1:0] cand, cand_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [2:0]        rcnt, rcnt_nxt;
    logic [CODE_W-1:0] bcd_nxt;
    logic              vld_nxt;

    assign sample_vld = i_pls_1k && (tick_cnt == TW'(SCAN_TICKS - 1));
    assign o_key_out  = ~(4'b0001 << col);

    // The column advances on the same edge that samples it, giving the next column a full scan period to settle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tick_cnt <= '0;
            col      <= 2'd0;
        end else if (i_pls_1k) begin
            if (sample_vld) begin
                tick_cnt <= '0;
                col      <= col + 2'd1;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    keypad_frame_acc u_frame_acc (
        .clk        (i_clk),
        .rst        (i_rst),
        .sample_vld (sample_vld),
        .col        (col),
        .rows_n     (i_key_in),
        .frame_vld  (frame_vld),
        .frame_kind (frame_kind),
        .frame_code (frame_code)
    );

    assign is_none   = (frame_kind == FR_NONE);
    assign is_single = (frame_kind == FR_SINGLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cand        <= '0;
            cnt         <= 3'd0;
            rcnt        <= 3'd0;
            o_bcd_data  <= '0;
            o_key_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            cand        <= cand_nxt;
            cnt         <= cnt_nxt;
            rcnt        <= rcnt_nxt;
            o_bcd_data  <= bcd_nxt;
            o_key_valid <= vld_nxt;
        end
    end

    // Multi-key frames break a candidate but keep a held key from being seen as released
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        rcnt_nxt  = rcnt;
        bcd_nxt   = o_bcd_data;
        vld_nxt   = 1'b0;
        if (frame_vld) begin
            case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_nxt = frame_code;
                        cnt_nxt  = 3'd1;
                        rcnt_nxt = 3'd0;
                        if (DEB_LIM <= 3'd1) begin
                            state_nxt = PRESSED;
                            bcd_nxt   = frame_code;
                            vld_nxt   = 1'b1;
                        end else begin
                            state_nxt = CAND;
                        end
                    end
                end
                CAND: begin
                    if (is_single && (frame_code == cand)) begin
                        if (cnt + 3'd1 >= DEB_LIM) begin
                            state_nxt = PRESSED;
                            cnt_nxt   = DEB_LIM;
                            rcnt_nxt  = 3'd0;
                            bcd_nxt   = cand;
                            vld_nxt   = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 3'd1;
                        end
                    end else if (is_single) begin
                        cand_nxt = frame_code;
                        cnt_nxt  = 3'd1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = 3'd0;
                    end
                end
                PRESSED: begin
                    if (is_none) begin
                        if (rcnt + 3'd1 >= REL_LIM) begin
                            state_nxt = IDLE;
                            rcnt_nxt  = 3'd0;
                            cnt_nxt   = 3'd0;
                        end else begin
                            rcnt_nxt = rcnt + 3'd1;
                        end
                    end else begin
                        rcnt_nxt = 3'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                    rcnt_nxt  = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad model drives rows from the held-key set and the live column drive.
// One "ms" is one i_pls_1k tick, issued every 5 clocks to keep runs short.
module tb_keypad_scan;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_pls_1k = 1'b0;
    logic [4:0] i_key_in;
    logic [3:0] o_key_out;
    logic [4:0] o_bcd_data;
    logic       o_key_valid;

    logic [19:0] held = '0;
    int checks = 0;
    int errors = 0;
    int ms_cnt = 0;
    int strobe_cnt = 0;
    int strobe_ms = -1;
    logic [4:0] strobe_code = '0;
    int long_strobes = 0;
    logic prev_vld = 1'b0;

    always #5 i_clk = ~i_clk;

    keypad_scan #(
        .SCAN_TICKS (2),
        .DEB_FRAMES (3),
        .REL_FRAMES (3)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_pls_1k    (i_pls_1k),
        .i_key_in    (i_key_in),
        .o_key_out   (o_key_out),
        .o_bcd_data  (o_bcd_data),
        .o_key_valid (o_key_valid)
    );

    // Passive matrix: a held key pulls its row low while its column is driven low
    always_comb begin
        i_key_in = 5'h1f;
        for (int c = 0; c < 4; c++)
            if (!o_key_out[c])
                for (int r = 0; r < 5; r++)
                    if (held[c*5+r]) i_key_in[r] = 1'b0;
    end

    always @(negedge i_clk) begin
        if (o_key_valid === 1'b1) begin
            strobe_cnt++;
            strobe_ms   = ms_cnt;
            strobe_code = o_bcd_data;
            if (prev_vld) long_strobes++;
        end
        prev_vld = (o_key_valid === 1'b1);
    end

    task automatic tick();
        @(negedge i_clk);
        i_pls_1k = 1'b1;
        ms_cnt++;
        @(negedge i_clk);
        i_pls_1k = 1'b0;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic run_ms(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst    = 1'b1;
        i_pls_1k = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst  = 1'b0;
        ms_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_key_out !== 4'b1110) begin
            errors++; $display("FAIL reset_key_out: got %b expected 1110", o_key_out);
        end
        checks++;
        if (o_bcd_data !== 5'd0) begin
            errors++; $display("FAIL reset_bcd: got %0d expected 0", o_bcd_data);
        end
        checks++;
        if (o_key_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", o_key_valid);
        end
    endtask

    task automatic test_scan();
        logic [3:0] col_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        int base;
        base = strobe_cnt;
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++;
            if (o_key_out !== col_exp[(n/2)%4]) begin
                errors++;
                $display("FAIL scan_col_tick%0d: got %b expected %b", n, o_key_out, col_exp[(n/2)%4]);
            end
        end
        repeat (40) @(negedge i_clk);
        checks++;
        if (o_key_out !== 4'b1110) begin
            errors++; $display("FAIL scan_frozen: got %b expected 1110", o_key_out);
        end
        tick();
        checks++;
        if (o_key_out !== 4'b1110) begin
            errors++; $display("FAIL scan_half_period: got %b expected 1110", o_key_out);
        end
        run_ms(91);
        checks++;
        if (strobe_cnt - base !== 0) begin
            errors++; $display("FAIL scan_no_strobe: got %0d strobes expected 0", strobe_cnt - base);
        end
    endtask

    task automatic test_press7();
        int base;
        do_reset();
        base = strobe_cnt;
        held = 20'd1 << 7;
        run_ms(40);
        checks++;
        if (strobe_cnt - base !== 1) begin
            errors++; $display("FAIL press7_count: got %0d expected 1", strobe_cnt - base);
        end
        checks++;
        if (strobe_code !== 5'd7) begin
            errors++; $display("FAIL press7_code: got %0d expected 7", strobe_code);
        end
        checks++;
        if (strobe_ms !== 24) begin
            errors++; $display("FAIL press7_latency: got %0d ms expected 24", strobe_ms);
        end
        checks++;
        if (o_bcd_data !== 5'd7) begin
            errors++; $display("FAIL press7_hold: got %0d expected 7", o_bcd_data);
        end
        held = '0;
        run_ms(32);
    endtask

    task automatic test_bounce();
        int base;
        do_reset();
        base = strobe_cnt;
        for (int i = 0; i < 60; i++) begin
            held = (i >= 15 || (i % 6) < 3) ? (20'd1 << 7) : 20'd0;
            tick();
        end
        checks++;
        if (strobe_cnt - base !== 1) begin
            errors++; $display("FAIL bounce_count: got %0d expected 1", strobe_cnt - base);
        end
        checks++;
        if (strobe_code !== 5'd7) begin
            errors++; $display("FAIL bounce_code: got %0d expected 7", strobe_code);
        end
        checks++;
        if (strobe_ms !== 40) begin
            errors++; $display("FAIL bounce_time: got %0d ms expected 40", strobe_ms);
        end
    endtask

    task automatic test_multi();
        int base;
        base = strobe_cnt;
        held = (20'd1 << 7) | (20'd1 << 12);
        run_ms(40);
        checks++;
        if (strobe_cnt - base !== 0) begin
            errors++; $display("FAIL multi_no_strobe: got %0d expected 0", strobe_cnt - base);
        end
        held = '0;
        run_ms(32);
        held = 20'd1 << 12;
        run_ms(40);
        checks++;
        if (strobe_cnt - base !== 1) begin
            errors++; $display("FAIL multi_repress_count: got %0d expected 1", strobe_cnt - base);
        end
        checks++;
        if (strobe_code !== 5'd12) begin
            errors++; $display("FAIL multi_repress_code: got %0d expected 12", strobe_code);
        end
    endtask

    task automatic test_reset_cand();
        int base;
        do_reset();
        held = 20'd1 << 19;
        base = strobe_cnt;
        run_ms(20);
        checks++;
        if (strobe_cnt - base !== 0) begin
            errors++; $display("FAIL cand_early_strobe: got %0d expected 0", strobe_cnt - base);
        end
        do_reset();
        checks++;
        if (o_key_out !== 4'b1110) begin
            errors++; $display("FAIL cand_rst_key_out: got %b expected 1110", o_key_out);
        end
        checks++;
        if (o_bcd_data !== 5'd0) begin
            errors++; $display("FAIL cand_rst_bcd: got %0d expected 0", o_bcd_data);
        end
        checks++;
        if (o_key_valid !== 1'b0) begin
            errors++; $display("FAIL cand_rst_valid: got %b expected 0", o_key_valid);
        end
        run_ms(23);
        checks++;
        if (strobe_cnt - base !== 0) begin
            errors++; $display("FAIL cand_partial_kept: got %0d expected 0", strobe_cnt - base);
        end
        run_ms(17);
        checks++;
        if (strobe_cnt - base !== 1) begin
            errors++; $display("FAIL cand19_count: got %0d expected 1", strobe_cnt - base);
        end
        checks++;
        if (strobe_code !== 5'd19) begin
            errors++; $display("FAIL cand19_code: got %0d expected 19", strobe_code);
        end
        checks++;
        if (strobe_ms !== 24) begin
            errors++; $display("FAIL cand19_time: got %0d ms expected 24", strobe_ms);
        end
    endtask

    task automatic test_hold0();
        int base;
        int first_ms;
        held = '0;
        run_ms(32);
        base = strobe_cnt;
        held = 20'd1;
        run_ms(500);
        checks++;
        if (strobe_cnt - base !== 1) begin
            errors++; $display("FAIL hold0_count: got %0d expected 1", strobe_cnt - base);
        end
        checks++;
        if (strobe_code !== 5'd0) begin
            errors++; $display("FAIL hold0_code: got %0d expected 0", strobe_code);
        end
        first_ms = strobe_ms;
        held = '0;
        run_ms(16);
        held = 20'd1;
        run_ms(40);
        checks++;
        if (strobe_cnt - base !== 1) begin
            errors++; $display("FAIL short_release: got %0d strobes expected 1", strobe_cnt - base);
        end
        held = '0;
        run_ms(32);
        held = 20'd1;
        run_ms(40);
        checks++;
        if (strobe_cnt - base !== 2) begin
            errors++; $display("FAIL full_release: got %0d strobes expected 2", strobe_cnt - base);
        end
        checks++;
        if (strobe_ms <= first_ms) begin
            errors++; $display("FAIL full_release_time: got %0d ms expected after %0d", strobe_ms, first_ms);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press7();
        test_bounce();
        test_multi();
        test_reset_cand();
        test_hold0();
        checks++;
        if (long_strobes !== 0) begin
            errors++; $display("FAIL strobe_width: got %0d multi-cycle strobes expected 0", long_strobes);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix keypad scanner and debouncer that feeds the calculator datapath. It drives the 4 keypad columns, samples the 5 row lines on the shared 1 kHz tick and rejects ghost or multi-key frames. It debounces both press and release, then emits one 5-bit key code with a single-cycle valid strobe per physical press. It sits between the keypad pins and the calculator/display stage, which consumes `o_bcd_data` / `o_key_valid`.

## Interface
- `SCAN_TICKS`, 2: `i_pls_1k` ticks each column stays driven (column period = 2 ms).
- `DEB_FRAMES`, 3: consecutive identical single-key frames required to accept a press (1..7).
- `REL_FRAMES`, 3: consecutive empty frames required to accept a release (1..7).

- `i_clk`  in  1  system clock; sole clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_pls_1k`  in  1  one-`i_clk`-wide tick at 1 kHz from the shared pulse generator.
- `i_key_in`  in  5  row inputs, active-low (pulled up; 0 = key pressed in the driven column).
- `o_key_out`  out  4  column drive, one-cold (exactly one bit 0 at all times).
- `o_bcd_data`  out  5  accepted key code 0..19; holds its value between strobes.
- `o_key_valid`  out  1  one-cycle strobe, new key accepted.

## Operation
- Column scan:
  - Column index c cycles 0→1→2→3→0.
  - `o_key_out = ~(4'b0001 << c)`.
  - A tick counter counts `i_pls_1k` pulses.
  - On the tick where the counter = SCAN_TICKS-1:
    - the rows are sampled for column c;
    - the counter clears;
    - c advances.
- Key code = c*5 + r, where r = row index 0..4 of a low bit.
- Frame:
  - A frame is the four column samples c=0..3.
  - Result is evaluated at the column-3 sample: NONE (no low bits in any column), SINGLE(k) (exactly one low bit in the whole frame), or MULTI (two or more low bits, possibly across columns).
  - MULTI is treated as NONE for press detection and as not-empty for release detection.
- Debounce FSM, evaluated once per frame:
  - IDLE:
    - SINGLE(k) → CAND with cand=k, cnt=1.
    - If DEB_FRAMES=1, go straight to PRESSED and accept.
  - CAND:
    - SINGLE(cand) → cnt+1. When cnt reaches DEB_FRAMES → PRESSED and accept.
    - SINGLE(other) → restart CAND with the new code, cnt=1.
    - NONE or MULTI → IDLE.
  - PRESSED:
    - NONE → rcnt+1. When rcnt reaches REL_FRAMES → IDLE.
    - Any non-NONE frame clears rcnt.
    - No auto-repeat. A different key while the first is still held is ignored until a full release.
  - Accept means: `o_bcd_data` ← cand and `o_key_valid` pulses.
- Codes 17..19 are valid scan codes and are reported like any other code. The meaning of each code (digit / operator) is defined in the shared package, not here.

## Timing
- Reset values:
  - `o_key_out` = 4'b1110 (column 0 driven).
  - `o_bcd_data` = 0, `o_key_valid` = 0.
  - FSM = IDLE; c, tick counter, cnt and rcnt = 0.
- Reset asserted mid-frame or mid-debounce discards all partial state. No strobe is issued for a key already held at reset release until DEB_FRAMES full frames are seen.
- Column change takes effect on the `i_clk` edge that samples the previous column. Rows are therefore sampled after SCAN_TICKS ms of settle.
- Strobe latency: `o_key_valid` is high for exactly one `i_clk` cycle, in the cycle after the column-3 sampling edge of the accepting frame. `o_bcd_data` is valid in that same cycle and stays stable afterwards.
- Worst-case press-to-strobe time with defaults: (DEB_FRAMES+1) frames = 32 ms. Minimum press-to-strobe time: 24 ms.
- `i_pls_1k` low: the scanner is frozen; outputs hold.
- Counters saturate at their limits and never wrap.

## Structure
- Shared package `calc_pkg` holds:
  - key-code constants (KEY_0..KEY_9, KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_EQ, KEY_CLR, KEY_BS; 17..19 reserved);
  - the FSM state encoding (IDLE, CAND, PRESSED);
  - NUM_COLS=4 and NUM_ROWS=5.
- One natural sub-module: `keypad_frame_acc`. It takes the column samples and produces the frame result (NONE/SINGLE/MULTI plus code) at frame end. The debounce FSM stays in `keypad_scan`.

## Test plan
- Reset release with no key pressed, 100 ms of ticks → `o_key_out` cycles 1110→1101→1011→0111 every 2 ms; `o_key_valid` never asserts.
- Row 2 held low only while column 1 is driven, stable for 40 ms → exactly one strobe, `o_bcd_data`=7, 24–32 ms after the press.
- Same key bouncing (toggling every 3 ms for 15 ms, then stable) → exactly one strobe with code 7, no earlier strobe.
- Code 7 held, then code 12 added (column 2, row 2) → MULTI frames, no new strobe; release both for ≥24 ms, then press 12 → one strobe, code 12.
- Hold code 0 for 500 ms → one strobe only. Release for 16 ms, repress → no second strobe. Release ≥24 ms, repress → second strobe.
- Assert `i_rst` in CAND at cnt=2 with code 19 held, then release reset → all outputs at reset values; strobe for code 19 only after 3 further full frames.
